// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state codes, parity helper and the
// command/response bytes used by both the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_INHIBIT = 3'd1,
    TX_REQ     = 3'd2,
    TX_SEND    = 3'd3,
    TX_ACK     = 3'd4,
    TX_RELEASE = 3'd5
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line with a registered falling-edge pulse.
// Flops reset to 1 so an idle (pulled-up) line never produces a spurious edge.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b1;
      sync_q <= 1'b1;
      prev   <= 1'b1;
      fall   <= 1'b0;
    end else begin
      meta   <= line;
      sync_q <= meta;
      prev   <= sync_q;
      fall   <= prev & ~sync_q;
    end
  end

  assign level = sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts a
// command byte out on device clock edges, checks the ACK and reports the result.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       PS2_clk,
  input  logic       PS2_dat,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_DAT  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_SAT   = TO_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'(TX_IDLE);
  localparam logic [2:0] S_INHIBIT = 3'(TX_INHIBIT);
  localparam logic [2:0] S_REQ     = 3'(TX_REQ);
  localparam logic [2:0] S_SEND    = 3'(TX_SEND);
  localparam logic [2:0] S_ACK     = 3'(TX_ACK);
  localparam logic [2:0] S_RELEASE = 3'(TX_RELEASE);

  logic [2:0]       state;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             clk_oe_q;
  logic             dat_oe_q;
  logic             done_q;
  logic             err_q;

  logic clk_level;
  logic clk_fall;
  logic dat_level;
  logic dat_fall_unused;
  logic timed_out;
  logic waiting_device;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (PS2_clk),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (PS2_dat),
    .level (dat_level),
    .fall  (dat_fall_unused)
  );

  // The timeout window covers everything after the clock line is released.
  assign waiting_device = (state == S_REQ) || (state == S_SEND) ||
                          (state == S_ACK) || (state == S_RELEASE);
  assign timed_out      = waiting_device && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      data_q   <= '0;
      parity_q <= 1'b0;
      bit_cnt  <= '0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (waiting_device && !timed_out && (to_cnt != TO_SAT)) begin
        to_cnt <= to_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (tx_start) begin
            data_q   <= tx_data;
            parity_q <= odd_parity(tx_data);
            inh_cnt  <= '0;
            bit_cnt  <= '0;
            clk_oe_q <= 1'b1;
            dat_oe_q <= (INHIBIT_CYCLES == 1);
            state    <= S_INHIBIT;
          end
        end

        // Start bit is asserted in the last inhibit cycle so data is already
        // low at the moment the clock line is let go.
        S_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b1;
            to_cnt   <= '0;
            state    <= S_REQ;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
            if (inh_cnt == INH_DAT) begin
              dat_oe_q <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (timed_out) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            err_q    <= 1'b1;
            state    <= S_IDLE;
          end else if (clk_fall) begin
            dat_oe_q <= ~data_q[0];
            bit_cnt  <= 4'd1;
            state    <= S_SEND;
          end
        end

        // bit_cnt holds the number of falling edges already consumed.
        S_SEND: begin
          if (timed_out) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            err_q    <= 1'b1;
            state    <= S_IDLE;
          end else if (clk_fall) begin
            if (bit_cnt == 4'd8) begin
              dat_oe_q <= ~parity_q;
            end else if (bit_cnt == 4'd9) begin
              dat_oe_q <= 1'b0;
              state    <= S_ACK;
            end else begin
              dat_oe_q <= ~data_q[bit_cnt[2:0]];
            end
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        // An ACK edge takes precedence over a coincident timeout.
        S_ACK: begin
          if (clk_fall) begin
            if (!dat_level) begin
              state <= S_RELEASE;
            end else begin
              err_q <= 1'b1;
              state <= S_IDLE;
            end
          end else if (timed_out) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            err_q    <= 1'b1;
            state    <= S_IDLE;
          end
        end

        S_RELEASE: begin
          if (timed_out) begin
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            err_q    <= 1'b1;
            state    <= S_IDLE;
          end else if (clk_level && dat_level) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end

        default: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_busy    = (state != S_IDLE);
  assign tx_done    = done_q;
  assign tx_err     = err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed plus randomized bench for ps2_host_tx with a behavioural PS/2 device
// that clocks frames, records the bits on the data line and ACKs or NACKs.
module tb_ps2_host_tx;

  localparam int INH  = 10;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       dev_clk;
  logic       dev_dat;
  logic       ps2_clk_pin;
  logic       ps2_dat_pin;

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  int err_total = 0;
  int both_total = 0;
  int busy_bad_total = 0;

  // Open-drain bus: either side can only pull a line low.
  assign ps2_clk_pin = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_pin = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .PS2_clk    (ps2_clk_pin),
    .PS2_dat    (ps2_dat_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_done) done_total++;
    if (tx_err) err_total++;
    if (tx_done && tx_err) both_total++;
    if ((tx_done || tx_err) && tx_busy) busy_bad_total++;
  end

  // Expected line image: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((b >> i) & 8'd1) != 0;
      ones += ((b >> i) & 8'd1) != 0 ? 1 : 0;
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // mode: 0 = ACK, 1 = NACK, 2 = never clock, 3 = reset at falling edge 5
  task automatic runDevice(input int mode, output logic [10:0] bits, output int busy_low,
                           output logic released);
    int waited;
    bits = '1;
    busy_low = 0;
    waited = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && waited < INH + 50) begin
      @(negedge clk);
      waited++;
    end
    released = (ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1);
    if (!released || mode == 2) return;
    repeat (HALF) @(negedge clk);
    bits[0] = ps2_dat_pin;
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (mode == 3 && k == 5) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("rst_mid_dat_oe", 32'(ps2_dat_oe), 32'd0);
        checkOutput("rst_mid_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dev_clk = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      if (k <= 10 && !tx_busy) busy_low++;
      dev_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      if (k <= 10) bits[k] = ps2_dat_pin;
      if (k == 10) dev_dat = (mode == 1);
      repeat (HALF / 2) @(negedge clk);
    end
    dev_dat = 1'b1;
  endtask

  task automatic waitPulse(input int d0, input int e0, output int waited);
    waited = 0;
    while (done_total == d0 && err_total == e0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
  endtask

  task automatic ackFrame(input string tag, input logic [7:0] b);
    logic [10:0] bits;
    int busy_low, waited, d0, e0;
    logic rel;
    d0 = done_total;
    e0 = err_total;
    applyStimulus(b);
    runDevice(0, bits, busy_low, rel);
    checkOutput({tag, "_released"}, 32'(rel), 32'd1);
    checkOutput({tag, "_bits"}, 32'(bits), 32'(exp_frame(b)));
    checkOutput({tag, "_busy_frame"}, 32'(busy_low), 32'd0);
    waitPulse(d0, e0, waited);
    checkOutput({tag, "_done_cnt"}, 32'(done_total - d0), 32'd1);
    checkOutput({tag, "_err_cnt"}, 32'(err_total - e0), 32'd0);
    checkOutput({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
    checkOutput({tag, "_idle_oe"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  orig;
    int busy_low, waited, hi, rise, n, d0, e0;
    logic rel;

    rst = 1'b1;
    tx_data = 8'h00;
    tx_start = 1'b0;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(tx_busy), 32'd0);
    checkOutput("reset_done", 32'(tx_done), 32'd0);
    checkOutput("reset_err", 32'(tx_err), 32'd0);
    checkOutput("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] frame 0xED with ACK and inhibit timing");
    d0 = done_total;
    e0 = err_total;
    applyStimulus(8'hED);
    checkOutput("start_busy", 32'(tx_busy), 32'd1);
    hi = 0;
    rise = 0;
    while (ps2_clk_oe === 1'b1 && hi < INH + 20) begin
      hi++;
      if (ps2_dat_oe === 1'b1 && rise == 0) rise = hi;
      @(negedge clk);
    end
    checkOutput("inhibit_len", 32'(hi), 32'(INH));
    checkOutput("start_bit_cycle", 32'(rise), 32'(INH));
    runDevice(0, bits, busy_low, rel);
    checkOutput("ed_bits", 32'(bits), 32'(exp_frame(8'hED)));
    checkOutput("ed_busy_frame", 32'(busy_low), 32'd0);
    waitPulse(d0, e0, waited);
    checkOutput("ed_done_cnt", 32'(done_total - d0), 32'd1);
    checkOutput("ed_err_cnt", 32'(err_total - e0), 32'd0);
    checkOutput("ed_idle_busy", 32'(tx_busy), 32'd0);

    $display("[TB] frame 0x00 with NACK");
    d0 = done_total;
    e0 = err_total;
    applyStimulus(8'h00);
    runDevice(1, bits, busy_low, rel);
    checkOutput("nack_bits", 32'(bits), 32'(exp_frame(8'h00)));
    checkOutput("nack_parity", 32'(bits[9]), 32'd1);
    waitPulse(d0, e0, waited);
    checkOutput("nack_err_cnt", 32'(err_total - e0), 32'd1);
    checkOutput("nack_done_cnt", 32'(done_total - d0), 32'd0);
    checkOutput("nack_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);

    $display("[TB] silent device timeout");
    e0 = err_total;
    d0 = done_total;
    applyStimulus(8'($urandom));
    runDevice(2, bits, busy_low, rel);
    checkOutput("silent_released", 32'(rel), 32'd1);
    n = 0;
    while (tx_err !== 1'b1 && n < TO + 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_cycles", 32'(n), 32'(TO));
    checkOutput("timeout_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    @(negedge clk);
    checkOutput("timeout_err_cnt", 32'(err_total - e0), 32'd1);
    checkOutput("timeout_done_cnt", 32'(done_total - d0), 32'd0);

    $display("[TB] start strobe while busy is ignored");
    orig = 8'($urandom_range(0, 254));
    d0 = done_total;
    e0 = err_total;
    applyStimulus(orig);
    fork
      runDevice(0, bits, busy_low, rel);
      begin
        repeat (200) @(negedge clk);
        tx_data = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    checkOutput("busy_start_bits", 32'(bits), 32'(exp_frame(orig)));
    waitPulse(d0, e0, waited);
    repeat (50) @(negedge clk);
    checkOutput("busy_start_done_cnt", 32'(done_total - d0), 32'd1);
    checkOutput("busy_start_no_new_frame", 32'({tx_busy, ps2_clk_oe}), 32'd0);

    $display("[TB] reset at falling edge 5, then 0xEE");
    d0 = done_total;
    e0 = err_total;
    applyStimulus(8'($urandom));
    runDevice(3, bits, busy_low, rel);
    repeat (5) @(negedge clk);
    checkOutput("after_rst_pulses", 32'((done_total - d0) + (err_total - e0)), 32'd0);
    ackFrame("ee", 8'hEE);

    $display("[TB] randomized ACKed frames");
    for (int r = 0; r < 4; r++) begin
      ackFrame("rand", 8'($urandom));
    end

    checkOutput("never_done_and_err", 32'(both_total), 32'd0);
    checkOutput("busy_clear_on_pulse", 32'(busy_bad_total), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
